// File: rtl/checkpoint_pkg.sv
// Shared types and default constants for the checkpoint reporter.
// The FSM is either idle or holding a code on the pads for its minimum time.
package checkpoint_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int          CKPT_WIDTH       = 16;
    localparam int          CKPT_DEPTH       = 4;
    localparam int          CKPT_HOLD_CYCLES = 64;
    localparam logic [15:0] CKPT_IDLE_CODE   = 16'h0000;

endpackage

// File: rtl/ckpt_fifo.sv
// Small synchronous FIFO that queues checkpoint codes.
// The head entry is visible combinationally so a pop can latch it at the same edge.
module ckpt_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only legal when a pop frees the slot at the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/checkpoint_reporter.sv
// Queues firmware checkpoint codes from LA probes and drives each onto the
// user pads for at least HOLD_CYCLES cycles so slow bench polling never misses one.
module checkpoint_reporter
    import checkpoint_pkg::*;
#(
    parameter int               WIDTH       = CKPT_WIDTH,
    parameter int               DEPTH       = CKPT_DEPTH,
    parameter int               HOLD_CYCLES = CKPT_HOLD_CYCLES,
    parameter logic [WIDTH-1:0] IDLE_CODE   = WIDTH'(CKPT_IDLE_CODE)
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic                       enable,
    input  logic                       push_toggle,
    input  logic [WIDTH-1:0]           push_code,
    input  logic                       clear_overflow,
    output logic [WIDTH-1:0]           io_out,
    output logic [WIDTH-1:0]           io_oeb,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       busy,
    output logic                       overflow
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] out_d;
    logic             toggle_q;
    logic             push_req;
    logic             pop;
    logic             fifo_push;
    logic             ovf_set;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;

    // toggle_q tracks the probe even while disabled, so enabling never fakes a push.
    assign push_req  = (push_toggle ^ toggle_q) & enable;
    assign fifo_push = push_req & (~full | pop);
    assign ovf_set   = push_req & full & ~pop;
    assign busy      = (state_q == HOLD) | ~empty;

    ckpt_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetb    (resetb),
        .push      (fifo_push),
        .pop       (pop),
        .flush     (~enable),
        .push_data (push_code),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = io_out;
        pop     = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = IDLE_CODE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        out_d   = head;
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!empty) begin
                        pop   = 1'b1;
                        out_d = head;
                        cnt_d = CW'(HOLD_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Overflow set wins over a same-edge clear so a drop is never lost.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            io_out   <= IDLE_CODE;
            io_oeb   <= '1;
            toggle_q <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            io_out   <= out_d;
            io_oeb   <= {WIDTH{~enable}};
            toggle_q <= push_toggle;
            if (ovf_set)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_checkpoint_reporter.sv
// Self-checking bench for checkpoint_reporter: a short vector table plus
// hand-written hold, back-to-back, overflow, reset and disable sequences.
module tb_checkpoint_reporter;

    logic        clock;
    logic        resetb;
    logic        enable;
    logic        push_toggle;
    logic [15:0] push_code;
    logic        clear_overflow;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        overflow;

    typedef struct {
        logic        en;
        logic        tog;
        logic [15:0] code;
        logic        clr;
        logic [15:0] out;
        logic [15:0] oeb;
        logic [2:0]  lvl;
        logic        bsy;
        logic        ovf;
    } vec_t;

    vec_t        vecs [5];
    logic [15:0] exp_q [$];
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          last_change;
    int          hold_len;
    logic [15:0] last_out;
    bit          mon_en;

    checkpoint_reporter dut (
        .clock          (clock),
        .resetb         (resetb),
        .enable         (enable),
        .push_toggle    (push_toggle),
        .push_code      (push_code),
        .clear_overflow (clear_overflow),
        .io_out         (io_out),
        .io_oeb         (io_oeb),
        .fifo_level     (fifo_level),
        .busy           (busy),
        .overflow       (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every new value on io_out must be the oldest code still owed by the scoreboard.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (mon_en && io_out !== last_out) begin
            hold_len    = cyc - last_change;
            last_change = cyc;
            if (exp_q.size() == 0)
                check_output("unexpected io_out change", {16'h0, io_out}, {16'h0, last_out});
            else
                check_output("scoreboard code", {16'h0, io_out}, {16'h0, exp_q.pop_front()});
        end
        last_out = io_out;
    endtask

    task automatic check_all(input string tag, input logic [15:0] out, input logic [15:0] oeb,
                             input logic [2:0] lvl, input logic bsy, input logic ovf);
        check_output({tag, " io_out"},     {16'h0, io_out},     {16'h0, out});
        check_output({tag, " io_oeb"},     {16'h0, io_oeb},     {16'h0, oeb});
        check_output({tag, " fifo_level"}, {29'h0, fifo_level}, {29'h0, lvl});
        check_output({tag, " busy"},       {31'h0, busy},       {31'h0, bsy});
        check_output({tag, " overflow"},   {31'h0, overflow},   {31'h0, ovf});
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.en && (v.tog != push_toggle)) exp_q.push_back(v.code);
        enable         = v.en;
        push_toggle    = v.tog;
        push_code      = v.code;
        clear_overflow = v.clr;
        step();
    endtask

    task automatic push_one(input logic [15:0] code, input bit accept);
        push_code   = code;
        push_toggle = ~push_toggle;
        if (accept) exp_q.push_back(code);
        step();
    endtask

    task automatic restart();
        mon_en         = 1'b0;
        resetb         = 1'b0;
        enable         = 1'b0;
        push_toggle    = 1'b0;
        push_code      = 16'h0;
        clear_overflow = 1'b0;
        #2;
        resetb = 1'b1;
        step();
        enable = 1'b1;
        step();
        exp_q.delete();
        last_out    = io_out;
        last_change = cyc;
        mon_en      = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            step();
        end
        check_output({tag, " codes outstanding"}, exp_q.size(), 0);
        check_output({tag, " busy after drain"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        cyc            = 0;
        last_change    = 0;
        hold_len       = 0;
        mon_en         = 1'b0;
        resetb         = 1'b0;
        enable         = 1'b0;
        push_toggle    = 1'b0;
        push_code      = 16'h0;
        clear_overflow = 1'b0;
        last_out       = 16'h0;

        // fields: en, tog, code, clr | io_out, io_oeb, level, busy, overflow
        vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'hAB41, 1'b0, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'hAB41, 1'b0, 16'hAB41, 16'h0000, 3'd0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'hAB41, 1'b0, 16'hAB41, 16'h0000, 3'd0, 1'b1, 1'b0};

        #7;
        check_all("reset", 16'h0000, 16'hFFFF, 3'd0, 1'b0, 1'b0);
        #5;
        resetb   = 1'b1;
        last_out = io_out;
        mon_en   = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i]);
            check_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].oeb, vecs[i].lvl,
                      vecs[i].bsy, vecs[i].ovf);
        end

        // Single code: popped at vec3's edge, so busy falls 64 edges later.
        repeat (62) step();
        check_output("single hold busy at 63", {31'h0, busy}, 32'h1);
        step();
        check_output("single hold busy at 64", {31'h0, busy}, 32'h0);
        repeat (5) step();
        check_output("single code persists", {16'h0, io_out}, 32'hAB41);

        $display("[TB] back-to-back codes");
        restart();
        push_one(16'hAB41, 1'b1);
        push_one(16'hAB51, 1'b1);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) step();
        check_output("b2b successor shown", exp_q.size(), 0);
        check_output("b2b hold length", hold_len, 64);
        check_output("b2b io_out", {16'h0, io_out}, 32'hAB51);
        drain("b2b", 100);

        $display("[TB] overflow");
        restart();
        for (int i = 1; i <= 5; i++) push_one(16'hC000 + 16'(i), 1'b1);
        push_one(16'hC006, 1'b0);
        check_output("ovf level", {29'h0, fifo_level}, 32'h4);
        check_output("ovf set", {31'h0, overflow}, 32'h1);
        repeat (3) step();
        check_output("ovf sticky", {31'h0, overflow}, 32'h1);
        clear_overflow = 1'b1;
        push_one(16'hC007, 1'b0);
        check_output("ovf set beats clear", {31'h0, overflow}, 32'h1);
        step();
        clear_overflow = 1'b0;
        check_output("ovf cleared", {31'h0, overflow}, 32'h0);
        drain("ovf", 400);

        $display("[TB] push on full at hold boundary");
        restart();
        for (int i = 1; i <= 5; i++) push_one(16'hD000 + 16'(i), 1'b1);
        check_output("boundary full", {29'h0, fifo_level}, 32'h4);
        repeat (60) step();
        check_output("boundary still full", {29'h0, fifo_level}, 32'h4);
        check_output("boundary first code", {16'h0, io_out}, 32'hD001);
        push_one(16'hD006, 1'b1);
        check_output("boundary level", {29'h0, fifo_level}, 32'h4);
        check_output("boundary overflow", {31'h0, overflow}, 32'h0);
        check_output("boundary hold length", hold_len, 64);
        drain("boundary", 400);

        $display("[TB] async reset mid-hold");
        restart();
        for (int i = 1; i <= 5; i++) push_one(16'hE000 + 16'(i), 1'b1);
        push_one(16'hE006, 1'b0);
        repeat (10) step();
        mon_en = 1'b0;
        #3;
        resetb = 1'b0;
        #1;
        check_all("async reset", 16'h0000, 16'hFFFF, 3'd0, 1'b0, 1'b0);
        #2;
        resetb = 1'b1;

        $display("[TB] disable mid-hold");
        restart();
        for (int i = 1; i <= 5; i++) push_one(16'hF000 + 16'(i), 1'b1);
        push_one(16'hF006, 1'b0);
        repeat (10) step();
        mon_en      = 1'b0;
        enable      = 1'b0;
        push_toggle = ~push_toggle;
        step();
        check_all("disable", 16'h0000, 16'hFFFF, 3'd0, 1'b0, 1'b1);
        push_toggle = ~push_toggle;
        step();
        push_toggle = ~push_toggle;
        step();
        enable = 1'b1;
        step();
        check_all("re-enable", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1);
        repeat (3) step();
        check_all("re-enable settled", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
